// File: rtl/alu_r1.sv
// alu_r1: execute-stage ALU with single-cycle R-type ops and an iterative mult/div unit owning hi/lo.
// Define ALU_R1_DIV_EN to compile in the restoring divider (DIV/DIVU); without it only MULT/MULTU start the unit.
module alu_r1 #(
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 6,
    parameter int STATUS_WIDTH = 4,
    parameter int SHAMT_WIDTH  = 5,
    parameter int OUT_REG      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*DATA_WIDTH-1:0]   dataIn,
    input  logic                      valid,
    input  logic [CTRL_WIDTH-1:0]     ctrl,
    input  logic [SHAMT_WIDTH-1:0]    shamt,
    output logic [DATA_WIDTH-1:0]     dataOut,
    output logic [STATUS_WIDTH-1:0]   status,
    output logic                      busy,
    output logic                      done
);

    // state | meaning
    // IDLE  | unit free, hi/lo stable, waiting for MULT/MULTU/DIV/DIVU
    // RUN   | one multiply or quotient bit per cycle, cnt counts down to 0
    // FIX   | sign correction, hi/lo write, done pulse follows

    localparam int W     = DATA_WIDTH;
    localparam int LOG2W = $clog2(W);
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [CTRL_WIDTH-1:0] F_SLL   = 'h00;
    localparam logic [CTRL_WIDTH-1:0] F_SRL   = 'h02;
    localparam logic [CTRL_WIDTH-1:0] F_SRA   = 'h03;
    localparam logic [CTRL_WIDTH-1:0] F_SLLV  = 'h04;
    localparam logic [CTRL_WIDTH-1:0] F_SRLV  = 'h05;
    localparam logic [CTRL_WIDTH-1:0] F_SRAV  = 'h07;
    localparam logic [CTRL_WIDTH-1:0] F_JR    = 'h08;
    localparam logic [CTRL_WIDTH-1:0] F_MFHI  = 'h10;
    localparam logic [CTRL_WIDTH-1:0] F_MTHI  = 'h11;
    localparam logic [CTRL_WIDTH-1:0] F_MFLO  = 'h12;
    localparam logic [CTRL_WIDTH-1:0] F_MTLO  = 'h13;
    localparam logic [CTRL_WIDTH-1:0] F_MULT  = 'h18;
    localparam logic [CTRL_WIDTH-1:0] F_MULTU = 'h19;
    localparam logic [CTRL_WIDTH-1:0] F_DIV   = 'h1A;
    localparam logic [CTRL_WIDTH-1:0] F_DIVU  = 'h1B;
    localparam logic [CTRL_WIDTH-1:0] F_ADD   = 'h20;
    localparam logic [CTRL_WIDTH-1:0] F_ADDU  = 'h21;
    localparam logic [CTRL_WIDTH-1:0] F_SUB   = 'h22;
    localparam logic [CTRL_WIDTH-1:0] F_SUBU  = 'h23;
    localparam logic [CTRL_WIDTH-1:0] F_AND   = 'h24;
    localparam logic [CTRL_WIDTH-1:0] F_OR    = 'h25;
    localparam logic [CTRL_WIDTH-1:0] F_XOR   = 'h26;
    localparam logic [CTRL_WIDTH-1:0] F_NOR   = 'h27;
    localparam logic [CTRL_WIDTH-1:0] F_SLT   = 'h2A;
    localparam logic [CTRL_WIDTH-1:0] F_SLTU  = 'h2B;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       hi, lo;
    logic [2*W-1:0]     acc;
    logic [W-1:0]       mcand;
    logic               neg_lo;

    logic [W-1:0]       op_a, op_b;
    logic [W:0]         add_ext, sub_ext;
    logic [LOG2W-1:0]   var_sh;
    logic [W-1:0]       res;
    logic               carry, ovf;
    logic [STATUS_WIDTH-1:0] st;

    assign op_a    = dataIn[W-1:0];
    assign op_b    = dataIn[2*W-1:W];
    assign add_ext = {1'b0, op_a} + {1'b0, op_b};
    assign sub_ext = {1'b0, op_a} - {1'b0, op_b};
    assign var_sh  = op_a[LOG2W-1:0];

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (ctrl)
            F_SLL:  res = op_b << shamt;
            F_SRL:  res = op_b >> shamt;
            F_SRA:  res = $signed(op_b) >>> shamt;
            F_SLLV: res = op_b << var_sh;
            F_SRLV: res = op_b >> var_sh;
            F_SRAV: res = $signed(op_b) >>> var_sh;
            F_JR:   res = op_a;
            F_MFHI: res = hi;
            F_MFLO: res = lo;
            F_ADD, F_ADDU: begin
                res   = add_ext[W-1:0];
                carry = add_ext[W];
                ovf   = (op_a[W-1] == op_b[W-1]) && (add_ext[W-1] != op_a[W-1]);
            end
            F_SUB, F_SUBU: begin
                res   = sub_ext[W-1:0];
                carry = ~sub_ext[W];
                ovf   = (op_a[W-1] != op_b[W-1]) && (sub_ext[W-1] != op_a[W-1]);
            end
            F_AND:  res = op_a & op_b;
            F_OR:   res = op_a | op_b;
            F_XOR:  res = op_a ^ op_b;
            F_NOR:  res = ~(op_a | op_b);
            F_SLT:  res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            F_SLTU: res = {{(W-1){1'b0}}, (op_a < op_b)};
            default: res = '0;
        endcase
    end

    assign st = {carry, (res == '0), res[W-1], ovf};

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dataOut <= '0;
                    status  <= '0;
                end else begin
                    dataOut <= res;
                    status  <= st;
                end
            end
        end else begin : g_comb
            assign dataOut = res;
            assign status  = st;
        end
    endgenerate

    // Start decode and operand magnitudes; signed ops run unsigned and fix signs at FIX.
    logic is_mul_op, is_div_op, op_signed, start;
    logic [W-1:0] a_mag, b_mag;

    assign is_mul_op = (ctrl == F_MULT) || (ctrl == F_MULTU);
`ifdef ALU_R1_DIV_EN
    assign is_div_op = (ctrl == F_DIV) || (ctrl == F_DIVU);
`else
    assign is_div_op = 1'b0;
`endif
    assign op_signed = (ctrl == F_MULT) || (ctrl == F_DIV);
    assign start     = valid && !busy && (is_mul_op || is_div_op);
    assign a_mag     = (op_signed && op_a[W-1]) ? (~op_a + 1'b1) : op_a;
    assign b_mag     = (op_signed && op_b[W-1]) ? (~op_b + 1'b1) : op_b;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next, prod_fix;

    assign mul_sum  = {1'b0, acc[2*W-1:W]} + ({1'b0, mcand} & {(W+1){acc[0]}});
    assign mul_next = {mul_sum, acc[W-1:1]};
    assign prod_fix = neg_lo ? (~acc + 1'b1) : acc;

`ifdef ALU_R1_DIV_EN
    logic           md_div, neg_hi, div_zero;
    logic [W-1:0]   dividend_raw;
    logic [W:0]     div_shift;
    logic [W+1:0]   div_diff;
    logic [2*W-1:0] div_next;
    logic [W-1:0]   quo_fix, rem_fix;

    // acc holds {remainder, dividend/quotient}; remainder never exceeds W bits for a nonzero divisor.
    assign div_shift = {acc[2*W-1:W], acc[W-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mcand};
    assign div_next  = div_diff[W+1] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                     : {div_diff[W-1:0],  acc[W-2:0], 1'b1};
    assign quo_fix   = neg_lo ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
    assign rem_fix   = neg_hi ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            mcand  <= '0;
            neg_lo <= 1'b0;
`ifdef ALU_R1_DIV_EN
            md_div       <= 1'b0;
            neg_hi       <= 1'b0;
            div_zero     <= 1'b0;
            dividend_raw <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (valid && !busy && ctrl == F_MTHI) hi <= op_a;
            if (valid && !busy && ctrl == F_MTLO) lo <= op_a;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        cnt    <= CNT_W'(W);
                        busy   <= 1'b1;
                        acc    <= {{W{1'b0}}, a_mag};
                        mcand  <= b_mag;
                        neg_lo <= op_signed && (op_a[W-1] ^ op_b[W-1]);
`ifdef ALU_R1_DIV_EN
                        md_div       <= is_div_op;
                        neg_hi       <= op_signed && op_a[W-1];
                        div_zero     <= (op_b == '0);
                        dividend_raw <= op_a;
`endif
                    end
                end
                S_RUN: begin
`ifdef ALU_R1_DIV_EN
                    acc <= md_div ? div_next : mul_next;
`else
                    acc <= mul_next;
`endif
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= S_FIX;
                end
                S_FIX: begin
`ifdef ALU_R1_DIV_EN
                    if (md_div) begin
                        hi <= div_zero ? dividend_raw : rem_fix;
                        lo <= div_zero ? {W{1'b1}} : quo_fix;
                    end else begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end
`else
                    hi <= prod_fix[2*W-1:W];
                    lo <= prod_fix[W-1:0];
`endif
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_r1.sv
// tb_alu_r1: vector table for single-cycle ops plus hand sequences for mult/div timing, busy and reset.
// Divider cases follow ALU_R1_DIV_EN the same way the design does.
module tb_alu_r1;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*W-1:0] dataIn;
    logic          valid;
    logic [5:0]    ctrl;
    logic [4:0]    shamt;
    logic [W-1:0]  dataOut;
    logic [3:0]    status;
    logic          busy;
    logic          done;

    alu_r1 #(.DATA_WIDTH(W), .CTRL_WIDTH(6), .STATUS_WIDTH(4), .SHAMT_WIDTH(5), .OUT_REG(0)) dut (
        .clk(clk), .rst(rst), .dataIn(dataIn), .valid(valid), .ctrl(ctrl), .shamt(shamt),
        .dataOut(dataOut), .status(status), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed { logic [31:0] data; logic [3:0] st; } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic [5:0]  c;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic [3:0]  st;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input string n, input logic [5:0] c, input logic [4:0] sh,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] d, input logic [3:0] s);
        vec_t v;
        v.name = n; v.c = c; v.sh = sh; v.a = a; v.b = b; v.data = d; v.st = s;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no entry expected one");
            e = '0;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic read_hilo(input string name);
        exp_t e;
        ctrl = 6'h10;
        #1;
        pop_exp(e);
        chk({name, "_hi"}, dataOut, e.data);
        ctrl = 6'h12;
        #1;
        pop_exp(e);
        chk({name, "_lo"}, dataOut, e.data);
    endtask

    task automatic wait_done(input time t0, input string name);
        int  cyc;
        time lat;
        cyc = 0;
        while (!done && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        lat = ($time - t0) / 10;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 80 cycles", name);
        end
        chk({name, "_latency"}, 32'(lat), 32'd33);
        chk({name, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic run_md(input string name, input logic [5:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        time t0;
        sb.push_back({exp_hi, 4'h0});
        sb.push_back({exp_lo, 4'h0});
        @(negedge clk);
        valid = 1'b1; ctrl = c; dataIn = {b, a};
        @(posedge clk);
        #1;
        t0 = $time;
        valid = 1'b0; ctrl = 6'h01;
        chk({name, "_busy_after_start"}, {31'b0, busy}, 32'd1);
        chk({name, "_done_after_start"}, {31'b0, done}, 32'd0);
        wait_done(t0, name);
        read_hilo(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        time  t0;
        int   dcount;

        rst = 1'b1; valid = 1'b0; ctrl = 6'h00; shamt = '0; dataIn = '0;
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        add_vec("mfhi_reset", 6'h10, 5'd0, 32'h0,        32'h0,        32'h00000000, 4'b0100);
        add_vec("mflo_reset", 6'h12, 5'd0, 32'h0,        32'h0,        32'h00000000, 4'b0100);
        add_vec("add_ovf",    6'h20, 5'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0011);
        add_vec("sub_0_1",    6'h22, 5'd0, 32'h0,        32'h1,        32'hFFFFFFFF, 4'b0010);
        add_vec("addu_wrap",  6'h21, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h00000000, 4'b1100);
        add_vec("subu_5_3",   6'h23, 5'd0, 32'h5,        32'h3,        32'h00000002, 4'b1000);
        add_vec("sub_ovf",    6'h22, 5'd0, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b1001);
        add_vec("sra_4",      6'h03, 5'd4, 32'h0,        32'h80000000, 32'hF8000000, 4'b0010);
        add_vec("srav_36",    6'h07, 5'd0, 32'd36,       32'h80000000, 32'hF8000000, 4'b0010);
        add_vec("srl_4",      6'h02, 5'd4, 32'h0,        32'h80000000, 32'h08000000, 4'b0000);
        add_vec("sll_31",     6'h00, 5'd31,32'h0,        32'h1,        32'h80000000, 4'b0010);
        add_vec("sllv_35",    6'h04, 5'd0, 32'h23,       32'h1,        32'h00000008, 4'b0000);
        add_vec("srlv_1",     6'h05, 5'd0, 32'h1,        32'h2,        32'h00000001, 4'b0000);
        add_vec("jr",         6'h08, 5'd0, 32'h12345678, 32'h9,        32'h12345678, 4'b0000);
        add_vec("and",        6'h24, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010);
        add_vec("or",         6'h25, 5'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b0010);
        add_vec("xor",        6'h26, 5'd0, 32'hFFFF0000, 32'hFFFF0000, 32'h00000000, 4'b0100);
        add_vec("nor",        6'h27, 5'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b0010);
        add_vec("slt_neg",    6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h00000001, 4'b0000);
        add_vec("sltu_big",   6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h00000000, 4'b0100);
        add_vec("undef_3f",   6'h3F, 5'd0, 32'h1,        32'h1,        32'h00000000, 4'b0100);
        add_vec("div_code",   6'h1A, 5'd0, 32'h7,        32'h2,        32'h00000000, 4'b0100);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            valid = 1'b0; ctrl = vecs[i].c; shamt = vecs[i].sh; dataIn = {vecs[i].b, vecs[i].a};
            sb.push_back({vecs[i].data, vecs[i].st});
            #1;
            pop_exp(e);
            chk({vecs[i].name, "_data"}, dataOut, e.data);
            chk({vecs[i].name, "_status"}, {28'b0, status}, {28'b0, e.st});
        end
        shamt = '0;

        sb.push_back({32'hAAAA0001, 4'h0});
        sb.push_back({32'h00005555, 4'h0});
        @(negedge clk);
        valid = 1'b1; ctrl = 6'h11; dataIn = {32'h0, 32'hAAAA0001};
        @(negedge clk);
        ctrl = 6'h13; dataIn = {32'h0, 32'h00005555};
        @(negedge clk);
        valid = 1'b0;
        read_hilo("mthi_mtlo");

        run_md("mult_neg2x3", 6'h18, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_md("multu_b2b",   6'h19, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        run_md("mult_neg_neg",6'h18, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'h00000000, 32'h00000015);

        // MTHI and a second MULT while busy must both be dropped; hi still holds the MULTU result (2).
        run_md("multu_reload",6'h19, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        sb.push_back({32'h00000000, 4'h0});
        sb.push_back({32'h00000023, 4'h0});
        @(negedge clk);
        valid = 1'b1; ctrl = 6'h18; dataIn = {32'd7, 32'd5};
        @(posedge clk);
        #1;
        t0 = $time;
        valid = 1'b0; ctrl = 6'h01;
        repeat (3) @(negedge clk);
        valid = 1'b1; ctrl = 6'h11; dataIn = {32'h0, 32'h00001234};
        @(negedge clk);
        ctrl = 6'h18; dataIn = {32'd9, 32'd9};
        @(negedge clk);
        valid = 1'b0; ctrl = 6'h10;
        #1;
        chk("mfhi_during_busy", dataOut, 32'h00000002);
        chk("busy_mid_run", {31'b0, busy}, 32'd1);
        wait_done(t0, "busy_ignore");
        read_hilo("busy_ignore");

        // Reset in the middle of a MULTU.
        @(negedge clk);
        valid = 1'b1; ctrl = 6'h11; dataIn = {32'h0, 32'hDEAD0000};
        @(negedge clk);
        ctrl = 6'h19; dataIn = {32'd4, 32'd3};
        @(posedge clk);
        #1;
        valid = 1'b0; ctrl = 6'h01;
        chk("rst_test_busy", {31'b0, busy}, 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        ctrl = 6'h10;
        #1;
        chk("rst_mid_hi", dataOut, 32'h0);
        ctrl = 6'h12;
        #1;
        chk("rst_mid_lo", dataOut, 32'h0);
        @(negedge clk);
        rst = 1'b0; ctrl = 6'h01;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        chk("rst_no_done_pulse", 32'(dcount), 32'd0);
        chk("rst_busy_after", {31'b0, busy}, 32'd0);

`ifdef ALU_R1_DIV_EN
        run_md("div_m7_2",    6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu_by0",    6'h1B, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
        run_md("div_min_m1",  6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_md("divu_100_7",  6'h1B, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
        run_md("div_7_m2",    6'h1A, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_md("div_by0_s",   6'h1A, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
`else
        sb.push_back({32'h00000011, 4'h0});
        sb.push_back({32'h00000022, 4'h0});
        @(negedge clk);
        valid = 1'b1; ctrl = 6'h11; dataIn = {32'h0, 32'h11};
        @(negedge clk);
        ctrl = 6'h13; dataIn = {32'h0, 32'h22};
        @(negedge clk);
        ctrl = 6'h1A; dataIn = {32'd2, 32'd7};
        #1;
        chk("nodiv_dataout", dataOut, 32'h0);
        @(posedge clk);
        #1;
        valid = 1'b0; ctrl = 6'h01;
        chk("nodiv_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("nodiv_busy_later", {31'b0, busy}, 32'd0);
        chk("nodiv_done", {31'b0, done}, 32'd0);
        read_hilo("nodiv_hilo");
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
